// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory fetch handshake.
//   req   : fetch request, driven by the fetch sequencer
//   addr  : word-aligned fetch byte address, driven by the fetch sequencer
//   ready : memory returns data this cycle (meaningful only while req=1)
//   rdata : instruction word, sampled when req & ready
// Modports: master = fetch sequencer, slave = instruction memory.
interface fetch_ctrl_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, fetches one word at a time over the
// imem handshake, holds it until the consumer accepts it, then picks the next PC from the
// jump/branch resolution presented with the accept.
// Ports:
//   Clock, Reset     : rising-edge clock, synchronous active-high reset
//   imem             : fetch_ctrl_if.master (req/addr out, ready/rdata in)
//   instr_valid      : instr/pc_out hold a fetched instruction
//   instr, pc_out    : held instruction and its address
//   instr_accept     : consumer takes instr; B/Z/J/target/B_addr valid alongside
//   next_pc          : pc_out + 4
//   target_addr      : jump destination {next_pc[31:28], target, 2'b00}
//   fetch_err        : sticky memory-timeout error
// Optional feature: define FETCH_TIMEOUT_EN to enable the request timeout and the error state.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic                Clock,
   input  logic                Reset,
   fetch_ctrl_if.master        imem,
   output logic                instr_valid,
   output logic [31:0]         instr,
   output logic [31:0]         pc_out,
   input  logic                instr_accept,
   input  logic                B,
   input  logic                Z,
   input  logic                J,
   input  logic [25:0]         target,
   input  logic [31:0]         B_addr,
   output logic [31:0]         next_pc,
   output logic [31:0]         target_addr,
   output logic                fetch_err
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("fetch_ctrl: TIMEOUT must be in 1..255");
   end
   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("fetch_ctrl: RESET_PC must be word aligned");
   end

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [1:0] {StIdle, StReq, StHold, StErr} state_e;
`else
   typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;
`endif

   state_e      state;
   logic        req_q;
   logic [31:0] pc_sel;

`ifdef FETCH_TIMEOUT_EN
   logic [7:0]  wait_cnt;
   logic        err_q;
   assign fetch_err = err_q;
`else
   assign fetch_err = 1'b0;
`endif

   assign imem.req    = req_q;
   assign imem.addr   = pc_out;
   assign next_pc     = pc_out + 32'd4;
   assign target_addr = {next_pc[31:28], target, 2'b00};

   // Jump beats branch; branch offset is a word offset, wrapping mod 2^32.
   always_comb begin
      pc_sel = next_pc;
      if (J) begin
         pc_sel = target_addr;
      end else if (B && Z) begin
         pc_sel = next_pc + (B_addr << 2);
      end
   end

   // req/valid are registered alongside the state so they carry no input-to-output path.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= StIdle;
         req_q       <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= 32'h0;
         pc_out      <= RESET_PC;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt    <= 8'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               state <= StReq;
               req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
               wait_cnt <= 8'd0;
`endif
            end
            StReq: begin
               if (imem.ready) begin
                  instr       <= imem.rdata;
                  state       <= StHold;
                  req_q       <= 1'b0;
                  instr_valid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
               end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                  // This unanswered cycle is the TIMEOUT-th one.
                  state <= StErr;
                  req_q <= 1'b0;
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
`endif
               end
            end
            StHold: begin
               if (instr_accept) begin
                  pc_out      <= pc_sel;
                  state       <= StReq;
                  req_q       <= 1'b1;
                  instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt    <= 8'd0;
`endif
               end
            end
`ifdef FETCH_TIMEOUT_EN
            StErr: begin
               // Held until Reset.
            end
`endif
            default: begin
               state       <= StIdle;
               req_q       <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. The bench plays instruction memory and the
// consumer, and predicts every PC from a transaction-level model of the next-PC rules.
module tb_fetch_ctrl;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int unsigned TB_TIMEOUT = 4;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic        instr_accept = 1'b0;
   logic        B = 1'b0;
   logic        Z = 1'b0;
   logic        J = 1'b0;
   logic [25:0] target = 26'h0;
   logic [31:0] B_addr = 32'h0;
   logic [31:0] next_pc;
   logic [31:0] target_addr;
   logic        fetch_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_pc;
   logic [31:0] exp_instr;

   fetch_ctrl_if imem ();

   fetch_ctrl #(
      .RESET_PC (RESET_PC),
      .TIMEOUT  (TB_TIMEOUT)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .imem         (imem),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .pc_out       (pc_out),
      .instr_accept (instr_accept),
      .B            (B),
      .Z            (Z),
      .J            (J),
      .target       (target),
      .B_addr       (B_addr),
      .next_pc      (next_pc),
      .target_addr  (target_addr),
      .fetch_err    (fetch_err)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Next PC from the accept-time resolution, in plain arithmetic.
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic b, input logic z,
                                             input logic j, input logic [25:0] tgt,
                                             input logic [31:0] off);
      logic [31:0] seq;
      seq = pc + 32'd4;
      if (j) return (seq & 32'hF000_0000) | (32'(tgt) * 32'd4);
      if (b && z) return seq + off * 32'd4;
      return seq;
   endfunction

   // Entered with the DUT requesting exp_pc; leaves it holding the word.
   task automatic do_fetch(input logic [31:0] word, input int waits);
      for (int i = 0; i < waits; i++) begin
         imem.ready   = 1'b0;
         imem.rdata   = $urandom;
         instr_accept = 1'($urandom % 2);   // must be ignored outside HOLD
         J            = 1'($urandom % 2);
         target       = 26'($urandom);
         #1;
         chk("req_wait", 32'(imem.req), 32'd1);
         chk("addr_wait", imem.addr, exp_pc);
         chk("valid_wait", 32'(instr_valid), 32'd0);
         chk("pc_wait", pc_out, exp_pc);
         step();
      end
      instr_accept = 1'b0;
      J            = 1'b0;
      imem.ready   = 1'b1;
      imem.rdata   = word;
      #1;
      chk("req_last", 32'(imem.req), 32'd1);
      chk("addr_last", imem.addr, exp_pc);
      step();
      imem.ready = 1'b0;
      exp_instr  = word;
      chk("valid_hold", 32'(instr_valid), 32'd1);
      chk("instr", instr, exp_instr);
      chk("pc_hold", pc_out, exp_pc);
      chk("req_hold", 32'(imem.req), 32'd0);
      chk("err_hold", 32'(fetch_err), 32'd0);
   endtask

   // Entered holding an instruction; leaves the DUT requesting the new PC.
   task automatic do_accept(input int stalls, input logic b, input logic z, input logic j,
                            input logic [25:0] tgt, input logic [31:0] off);
      for (int i = 0; i < stalls; i++) begin
         instr_accept = 1'b0;
         imem.ready   = 1'($urandom % 2);   // must be ignored outside REQ
         imem.rdata   = $urandom;
         #1;
         chk("valid_stall", 32'(instr_valid), 32'd1);
         chk("instr_stall", instr, exp_instr);
         chk("pc_stall", pc_out, exp_pc);
         chk("req_stall", 32'(imem.req), 32'd0);
         step();
      end
      imem.ready   = 1'b0;
      instr_accept = 1'b1;
      B            = b;
      Z            = z;
      J            = j;
      target       = tgt;
      B_addr       = off;
      #1;
      chk("next_pc", next_pc, exp_pc + 32'd4);
      chk("target_addr", target_addr, model_next(exp_pc, 1'b0, 1'b0, 1'b1, tgt, off));
      step();
      instr_accept = 1'b0;
      B            = 1'b0;
      Z            = 1'b0;
      J            = 1'b0;
      exp_pc       = model_next(exp_pc, b, z, j, tgt, off);
      chk("req_new", 32'(imem.req), 32'd1);
      chk("addr_new", imem.addr, exp_pc);
      chk("pc_new", pc_out, exp_pc);
      chk("valid_new", 32'(instr_valid), 32'd0);
   endtask

   initial begin
      imem.ready = 1'b0;
      imem.rdata = 32'h0;
      exp_pc     = RESET_PC;
      exp_instr  = 32'h0;

      // Reset for two cycles.
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_req", 32'(imem.req), 32'd0);
         chk("rst_valid", 32'(instr_valid), 32'd0);
         chk("rst_instr", instr, 32'h0);
         chk("rst_pc", pc_out, RESET_PC);
         chk("rst_next_pc", next_pc, RESET_PC + 32'd4);
         chk("rst_err", 32'(fetch_err), 32'd0);
      end
      Reset = 1'b0;
      step();
      chk("first_req", 32'(imem.req), 32'd1);
      chk("first_addr", imem.addr, RESET_PC);
      chk("first_valid", 32'(instr_valid), 32'd0);

      // Zero-wait sequential stream.
      do_fetch(32'h1111_1111, 0);
      do_accept(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
      do_fetch(32'h2222_2222, 0);
      do_accept(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
      do_fetch(32'h3333_3333, 0);
      do_accept(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);

      // Back to 0, then jump/branch cases.
      Reset = 1'b1;
      step();
      Reset  = 1'b0;
      exp_pc = RESET_PC;
      step();
      do_fetch(32'hA000_0001, 0);
      do_accept(0, 1'b0, 1'b0, 1'b1, 26'h000_0005, 32'h0);          // -> 0x14
      chk("jump_addr", imem.addr, 32'h0000_0014);
      do_fetch(32'hA000_0002, 0);
      do_accept(0, 1'b0, 1'b0, 1'b1, 26'h000_0004, 32'h0);          // -> 0x10
      do_fetch(32'hA000_0003, 0);
      do_accept(0, 1'b1, 1'b1, 1'b0, 26'h0, 32'hFFFF_FFFE);         // taken -> 0xC
      chk("branch_taken", imem.addr, 32'h0000_000C);
      do_fetch(32'hA000_0004, 0);
      do_accept(0, 1'b0, 1'b0, 1'b1, 26'h000_0004, 32'h0);          // -> 0x10
      do_fetch(32'hA000_0005, 0);
      do_accept(0, 1'b1, 1'b0, 1'b0, 26'h0, 32'hFFFF_FFFE);         // not taken -> 0x14
      chk("branch_not_taken", imem.addr, 32'h0000_0014);
      do_fetch(32'hA000_0006, 0);
      do_accept(0, 1'b1, 1'b1, 1'b1, 26'h000_0007, 32'hFFFF_FFFE);  // jump wins -> 0x1C
      chk("jump_over_branch", imem.addr, 32'h0000_001C);

      // Memory waits and consumer stalls.
      do_fetch(32'hB0B0_B0B0, 3);
      do_accept(4, 1'b1, 1'b1, 1'b0, 26'h0, 32'hFFFF_FFF7);         // 0x20 - 36 -> 0xFFFF_FFFC
      chk("pc_top", imem.addr, 32'hFFFF_FFFC);
      do_fetch(32'hC0C0_C0C0, 1);
      do_accept(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);                 // wraps to 0
      chk("pc_wrap", imem.addr, 32'h0000_0000);

      // Randomized transactions.
      for (int n = 0; n < 40; n++) begin
         do_fetch($urandom, int'($urandom_range(0, 3)));
         do_accept(int'($urandom_range(0, 3)), 1'($urandom % 2), 1'($urandom % 2),
                   1'($urandom_range(0, 3) == 0), 26'($urandom),
                   32'($urandom_range(0, 127)) - 32'd64);
      end

      // Reset during REQ with ready high: data must not be captured.
      do_fetch(32'hD0D0_D0D0, 0);
      do_accept(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
      Reset      = 1'b1;
      imem.ready = 1'b1;
      imem.rdata = 32'hDEAD_BEEF;
      step();
      Reset      = 1'b0;
      imem.ready = 1'b0;
      exp_pc     = RESET_PC;
      chk("rreq_req", 32'(imem.req), 32'd0);
      chk("rreq_valid", 32'(instr_valid), 32'd0);
      chk("rreq_instr", instr, 32'h0);
      chk("rreq_pc", pc_out, RESET_PC);
      step();
      chk("rreq_next_req", 32'(imem.req), 32'd1);
      chk("rreq_next_addr", imem.addr, RESET_PC);

      // Reset while holding.
      do_fetch(32'hE0E0_E0E0, 0);
      do_accept(0, 1'b0, 1'b0, 1'b1, 26'h0000_123, 32'h0);
      do_fetch(32'hF0F0_F0F0, 0);
      Reset = 1'b1;
      step();
      Reset  = 1'b0;
      exp_pc = RESET_PC;
      chk("rhold_valid", 32'(instr_valid), 32'd0);
      chk("rhold_pc", pc_out, RESET_PC);
      chk("rhold_instr", instr, 32'h0);
      step();
      chk("rhold_addr", imem.addr, RESET_PC);

`ifdef FETCH_TIMEOUT_EN
      // Unanswered request: error after the TB_TIMEOUT-th wait cycle, sticky until reset.
      imem.ready = 1'b0;
      for (int i = 0; i < int'(TB_TIMEOUT) - 1; i++) begin
         step();
         chk("to_wait_req", 32'(imem.req), 32'd1);
         chk("to_wait_err", 32'(fetch_err), 32'd0);
      end
      step();
      for (int i = 0; i < 3; i++) begin
         chk("to_err", 32'(fetch_err), 32'd1);
         chk("to_req", 32'(imem.req), 32'd0);
         chk("to_valid", 32'(instr_valid), 32'd0);
         imem.ready = 1'b1;
         step();
      end
      imem.ready = 1'b0;
      Reset      = 1'b1;
      step();
      Reset = 1'b0;
      chk("to_rst_err", 32'(fetch_err), 32'd0);
      chk("to_rst_req", 32'(imem.req), 32'd0);
      step();
      chk("to_restart", 32'(imem.req), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
